// File: rtl/regfile_sb_if.sv
// Register file bus: write, reserve and dual-read signals grouped for regfile_sb.
// The controller side uses the master modport and the register file uses the slave modport.
interface regfile_sb_if #(
    parameter int W  = 16,
    parameter int AW = 3
);
    logic [W-1:0]  data_in;
    logic [AW-1:0] writenum;
    logic          write;
    logic          reserve;
    logic [AW-1:0] reservenum;
    logic [AW-1:0] readnum_a;
    logic [AW-1:0] readnum_b;
    logic [W-1:0]  data_out_a;
    logic [W-1:0]  data_out_b;
    logic          busy_a;
    logic          busy_b;
    logic [AW:0]   busy_count;

    modport master (
        output data_in, writenum, write, reserve, reservenum, readnum_a, readnum_b,
        input  data_out_a, data_out_b, busy_a, busy_b, busy_count
    );

    modport slave (
        input  data_in, writenum, write, reserve, reservenum, readnum_a, readnum_b,
        output data_out_a, data_out_b, busy_a, busy_b, busy_count
    );
endinterface

// File: rtl/regfile_sb.sv
// Parametrised register file with two combinational read ports, optional
// write-to-read bypass, a per-register busy scoreboard and an optional
// hardwired-zero R0. Reset is synchronous and active-low.
module regfile_sb #(
    parameter int W       = 16,
    parameter int AW      = 3,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    regfile_sb_if.slave   bus
);
    localparam int N      = 2 ** AW;
    localparam bit BYP_EN = (BYPASS != 0);
    localparam bit ZR0_EN = (ZERO_R0 != 0);

    logic [W-1:0]  regs [N];
    logic [N-1:0]  busy;
    logic [N-1:0]  busy_next;
    logic [AW:0]   busy_count_q;
    logic [AW:0]   count_next;
    logic          write_en;
    logic          reserve_en;
    logic          hit_a;
    logic          hit_b;
    logic          zero_a;
    logic          zero_b;

    // Writes and reservations aimed at a hardwired-zero R0 are dropped here,
    // so R0 can never hold data or become busy.
    always_comb begin
        write_en   = bus.write;
        reserve_en = bus.reserve;
        if (ZR0_EN && (bus.writenum == '0)) begin
            write_en = 1'b0;
        end
        if (ZR0_EN && (bus.reservenum == '0)) begin
            reserve_en = 1'b0;
        end
    end

    // Next busy vector: writeback clears, then reserve sets, so a same-index
    // reserve wins because a new producer has been issued.
    always_comb begin
        busy_next = busy;
        if (write_en) begin
            busy_next[bus.writenum] = 1'b0;
        end
        if (reserve_en) begin
            busy_next[bus.reservenum] = 1'b1;
        end
    end

    // Population count of the updated busy vector, registered below.
    always_comb begin
        count_next = '0;
        for (int i = 0; i < N; i++) begin
            count_next = count_next + (AW+1)'(busy_next[i]);
        end
    end

    // Storage, scoreboard and count update; reset overrides write and reserve.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                regs[i] <= '0;
            end
            busy         <= '0;
            busy_count_q <= '0;
        end else begin
            if (write_en) begin
                regs[bus.writenum] <= bus.data_in;
            end
            busy         <= busy_next;
            busy_count_q <= count_next;
        end
    end

    // Read-port qualifiers: hardwired-zero detection and bypass hit per port.
    always_comb begin
        zero_a = ZR0_EN && (bus.readnum_a == '0);
        zero_b = ZR0_EN && (bus.readnum_b == '0);
        hit_a  = BYP_EN && bus.write && (bus.writenum == bus.readnum_a) && !zero_a;
        hit_b  = BYP_EN && bus.write && (bus.writenum == bus.readnum_b) && !zero_b;
    end

    // Port A read: zero for hardwired R0, forwarded write data on a bypass hit.
    always_comb begin
        bus.data_out_a = regs[bus.readnum_a];
        bus.busy_a     = busy[bus.readnum_a];
        if (zero_a) begin
            bus.data_out_a = '0;
            bus.busy_a     = 1'b0;
        end else if (hit_a) begin
            bus.data_out_a = bus.data_in;
            bus.busy_a     = 1'b0;
        end
    end

    // Port B read: identical to port A so both ports agree on a shared index.
    always_comb begin
        bus.data_out_b = regs[bus.readnum_b];
        bus.busy_b     = busy[bus.readnum_b];
        if (zero_b) begin
            bus.data_out_b = '0;
            bus.busy_b     = 1'b0;
        end else if (hit_b) begin
            bus.data_out_b = bus.data_in;
            bus.busy_b     = 1'b0;
        end
    end

    assign bus.busy_count = busy_count_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed testbench for regfile_sb. Three instances share one stimulus:
// u0 (bypass, normal R0), u1 (no bypass) and u2 (bypass, hardwired-zero R0).
module tb_regfile_sb;
    logic        clk;
    logic        rst_n;
    logic [15:0] data_in;
    logic [2:0]  writenum;
    logic        write;
    logic        reserve;
    logic [2:0]  reservenum;
    logic [2:0]  readnum_a;
    logic [2:0]  readnum_b;

    int testsRun;
    int testsFailed;

    regfile_sb_if #(.W(16), .AW(3)) if0 ();
    regfile_sb_if #(.W(16), .AW(3)) if1 ();
    regfile_sb_if #(.W(16), .AW(3)) if2 ();

    assign if0.data_in = data_in;    assign if1.data_in = data_in;    assign if2.data_in = data_in;
    assign if0.writenum = writenum;  assign if1.writenum = writenum;  assign if2.writenum = writenum;
    assign if0.write = write;        assign if1.write = write;        assign if2.write = write;
    assign if0.reserve = reserve;    assign if1.reserve = reserve;    assign if2.reserve = reserve;
    assign if0.reservenum = reservenum; assign if1.reservenum = reservenum; assign if2.reservenum = reservenum;
    assign if0.readnum_a = readnum_a; assign if1.readnum_a = readnum_a; assign if2.readnum_a = readnum_a;
    assign if0.readnum_b = readnum_b; assign if1.readnum_b = readnum_b; assign if2.readnum_b = readnum_b;

    regfile_sb #(.W(16), .AW(3), .BYPASS(1), .ZERO_R0(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    regfile_sb #(.W(16), .AW(3), .BYPASS(0), .ZERO_R0(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    regfile_sb #(.W(16), .AW(3), .BYPASS(1), .ZERO_R0(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

    // 10-unit clock period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it does not match.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive write/reserve controls for the next edge.
    task automatic applyStimulus(input logic w, input logic [2:0] wn, input logic [15:0] din,
                                 input logic r, input logic [2:0] rn);
        write      = w;
        writenum   = wn;
        data_in    = din;
        reserve    = r;
        reservenum = rn;
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0);
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst_n       = 1'b0;
        readnum_a   = 3'd0;
        readnum_b   = 3'd0;
        idle();
        #1;
        step();
        step();
        rst_n = 1'b1;

        // Reset state: every register zero and idle on both ports
        for (int i = 0; i < 8; i++) begin
            readnum_a = 3'(i);
            readnum_b = 3'(7 - i);
            #1;
            checkOutput($sformatf("rst_a%0d", i), if0.data_out_a, 32'h0);
            checkOutput($sformatf("rst_b%0d", i), if0.data_out_b, 32'h0);
            checkOutput($sformatf("rst_busy%0d", i), {if0.busy_a, if0.busy_b}, 32'h0);
        end
        checkOutput("rst_cnt0", if0.busy_count, 32'h0);
        checkOutput("rst_cnt2", if2.busy_count, 32'h0);

        // Write and read back through both ports
        applyStimulus(1'b1, 3'd3, 16'h1234, 1'b0, 3'd0);
        step();
        applyStimulus(1'b1, 3'd5, 16'hBEEF, 1'b0, 3'd0);
        step();
        idle();
        readnum_a = 3'd3;
        readnum_b = 3'd5;
        #1;
        checkOutput("wr_a3", if0.data_out_a, 32'h1234);
        checkOutput("wr_b5", if0.data_out_b, 32'hBEEF);
        checkOutput("wr_a3_nb", if1.data_out_a, 32'h1234);
        readnum_a = 3'd5;
        #1;
        checkOutput("same_a5", if0.data_out_a, 32'hBEEF);
        checkOutput("same_b5", if0.data_out_b, 32'hBEEF);

        // Bypass: same-cycle forwarding only in the bypass instances
        applyStimulus(1'b1, 3'd2, 16'h0001, 1'b0, 3'd0);
        step();
        applyStimulus(1'b1, 3'd2, 16'h00FF, 1'b0, 3'd0);
        readnum_a = 3'd2;
        readnum_b = 3'd3;
        #1;
        checkOutput("byp_a", if0.data_out_a, 32'h00FF);
        checkOutput("nobyp_a", if1.data_out_a, 32'h0001);
        checkOutput("byp_other_b", if0.data_out_b, 32'h1234);
        step();
        idle();
        #1;
        checkOutput("nobyp_after", if1.data_out_a, 32'h00FF);

        // Scoreboard: reserve, writeback clear, bypass masks busy
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b1, 3'd4);
        step();
        idle();
        readnum_a = 3'd4;
        #1;
        checkOutput("rsv_busy", if0.busy_a, 32'h1);
        checkOutput("rsv_cnt", if0.busy_count, 32'h1);
        applyStimulus(1'b1, 3'd4, 16'h00AA, 1'b0, 3'd0);
        #1;
        checkOutput("byp_busy_mask", if0.busy_a, 32'h0);
        checkOutput("nobyp_busy", if1.busy_a, 32'h1);
        step();
        idle();
        #1;
        checkOutput("wb_busy", if0.busy_a, 32'h0);
        checkOutput("wb_cnt", if0.busy_count, 32'h0);
        checkOutput("wb_data", if1.data_out_a, 32'h00AA);
        applyStimulus(1'b1, 3'd4, 16'h0055, 1'b1, 3'd4);
        step();
        idle();
        #1;
        checkOutput("rsv_wins_busy", if0.busy_a, 32'h1);
        checkOutput("rsv_wins_data", if0.data_out_a, 32'h0055);
        checkOutput("rsv_wins_cnt", if0.busy_count, 32'h1);
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b1, 3'd4);
        step();
        idle();
        #1;
        checkOutput("rsv_again_cnt", if0.busy_count, 32'h1);
        applyStimulus(1'b1, 3'd4, 16'h0066, 1'b1, 3'd6);
        step();
        idle();
        readnum_b = 3'd6;
        #1;
        checkOutput("diff_busy4", if0.busy_a, 32'h0);
        checkOutput("diff_busy6", if0.busy_b, 32'h1);
        checkOutput("diff_data4", if0.data_out_a, 32'h0066);
        checkOutput("diff_cnt", if0.busy_count, 32'h1);

        // Reset mid-operation discards the concurrent write and reserve
        applyStimulus(1'b1, 3'd7, 16'h7777, 1'b1, 3'd1);
        step();
        idle();
        readnum_a = 3'd7;
        readnum_b = 3'd1;
        #1;
        checkOutput("pre_rst_cnt", if0.busy_count, 32'h2);
        checkOutput("pre_rst_r7", if0.data_out_a, 32'h7777);
        checkOutput("pre_rst_b1", if0.busy_b, 32'h1);
        applyStimulus(1'b1, 3'd7, 16'h9999, 1'b1, 3'd3);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_pending_cnt", if1.busy_count, 32'h2);
        step();
        rst_n = 1'b1;
        idle();
        readnum_b = 3'd3;
        #1;
        checkOutput("mid_rst_r7", if0.data_out_a, 32'h0);
        checkOutput("mid_rst_r7_nb", if1.data_out_a, 32'h0);
        checkOutput("mid_rst_cnt", if0.busy_count, 32'h0);
        checkOutput("mid_rst_b3", if0.busy_b, 32'h0);
        checkOutput("mid_rst_cnt2", if2.busy_count, 32'h0);

        // Hardwired-zero R0: writes, reservations and bypass ignored for index 0
        applyStimulus(1'b1, 3'd0, 16'hFFFF, 1'b0, 3'd0);
        readnum_a = 3'd0;
        readnum_b = 3'd0;
        #1;
        checkOutput("z_byp_a", if2.data_out_a, 32'h0);
        checkOutput("nz_byp_a", if0.data_out_a, 32'hFFFF);
        step();
        idle();
        #1;
        checkOutput("z_r0", if2.data_out_b, 32'h0);
        checkOutput("nz_r0", if0.data_out_b, 32'hFFFF);
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b1, 3'd0);
        step();
        idle();
        #1;
        checkOutput("z_busy", if2.busy_a, 32'h0);
        checkOutput("z_cnt", if2.busy_count, 32'h0);
        checkOutput("nz_busy", if0.busy_a, 32'h1);
        checkOutput("nz_cnt", if0.busy_count, 32'h1);
        applyStimulus(1'b1, 3'd1, 16'h0C0C, 1'b1, 3'd2);
        step();
        idle();
        readnum_a = 3'd1;
        readnum_b = 3'd2;
        #1;
        checkOutput("z_r1", if2.data_out_a, 32'h0C0C);
        checkOutput("z_busy2", if2.busy_b, 32'h1);
        checkOutput("z_cnt2", if2.busy_count, 32'h1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
